// File: rtl/gobou_layer_seq.sv
// -----------------------------------------------------------------------------
// gobou_layer_seq
// Layer scheduler for the gobou fully-connected engine. A small descriptor
// table (one entry per layer: total_in, total_out, input_addr, output_addr)
// is loaded by the host while idle. One start pulse then runs the first
// min(num_layer, MAXLAYER) layers back-to-back. Each layer's descriptor is
// presented, req is pulsed, and the sequencer waits for gobou's ack. Entries
// with a zero unit count are skipped without issuing req.
//
// Ports
//   clk, xrst          clock, asynchronous active-low reset
//   cfg_we/cfg_layer   descriptor write strobe and index (ignored while busy)
//   cfg_total_in/out   unit counts written to the selected entry
//   cfg_input/output_addr  image-memory base addresses written to the entry
//   num_layer          number of layers to run, sampled with start
//   start              single-cycle launch request
//   ack                gobou layer-complete pulse
//   req                single-cycle launch pulse to gobou
//   total_in/out, input_addr, output_addr   active descriptor to gobou
//   cur_layer          index of the layer being fetched/run
//   busy               sequence in progress
//   done               single-cycle completion pulse
// -----------------------------------------------------------------------------
module gobou_layer_seq #(
   parameter int LWIDTH   = 10,
   parameter int IMGSIZE  = 12,
   parameter int MAXLAYER = 8,
   parameter int LAYERLOG = 3
) (
   input  logic                clk,
   input  logic                xrst,
   input  logic                cfg_we,
   input  logic [LAYERLOG-1:0] cfg_layer,
   input  logic [LWIDTH-1:0]   cfg_total_in,
   input  logic [LWIDTH-1:0]   cfg_total_out,
   input  logic [IMGSIZE-1:0]  cfg_input_addr,
   input  logic [IMGSIZE-1:0]  cfg_output_addr,
   input  logic [LAYERLOG:0]   num_layer,
   input  logic                start,
   input  logic                ack,
   output logic                req,
   output logic [LWIDTH-1:0]   total_in,
   output logic [LWIDTH-1:0]   total_out,
   output logic [IMGSIZE-1:0]  input_addr,
   output logic [IMGSIZE-1:0]  output_addr,
   output logic [LAYERLOG-1:0] cur_layer,
   output logic                busy,
   output logic                done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_FIN   = 3'd4
   } state_e;

   localparam logic [LAYERLOG:0]   MAX_CNT  = (LAYERLOG+1)'(MAXLAYER);
   localparam logic [LAYERLOG:0]   ONE_CNT  = (LAYERLOG+1)'(1);
   localparam logic [LAYERLOG:0]   ZERO_CNT = (LAYERLOG+1)'(0);
   localparam logic [LAYERLOG-1:0] ONE_LYR  = LAYERLOG'(1);
   localparam logic [LAYERLOG-1:0] ZERO_LYR = LAYERLOG'(0);

   state_e                state_q, state_d;
   // launch_q marks the cycle after start, in which the latched count decides
   // between fetching the first layer and finishing straight away.
   logic                  launch_q, launch_d;
   logic [LAYERLOG:0]     count_q, count_d;
   logic [LAYERLOG-1:0]   cur_layer_q, cur_layer_d;
   logic                  req_q, req_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic [LWIDTH-1:0]     tin_q, tin_d;
   logic [LWIDTH-1:0]     tout_q, tout_d;
   logic [IMGSIZE-1:0]    iaddr_q, iaddr_d;
   logic [IMGSIZE-1:0]    oaddr_q, oaddr_d;

   logic [LWIDTH-1:0]     tab_in_q   [MAXLAYER];
   logic [LWIDTH-1:0]     tab_out_q  [MAXLAYER];
   logic [IMGSIZE-1:0]    tab_iaddr_q[MAXLAYER];
   logic [IMGSIZE-1:0]    tab_oaddr_q[MAXLAYER];

   logic                  entry_empty_s;
   logic                  last_layer_s;

   assign entry_empty_s = (tab_in_q[cur_layer_q]  == {LWIDTH{1'b0}}) ||
                          (tab_out_q[cur_layer_q] == {LWIDTH{1'b0}});
   assign last_layer_s  = (({1'b0, cur_layer_q} + ONE_CNT) == count_q);

   // Descriptor table: host writes land only while no sequence is running.
   always_ff @(posedge clk) begin
      if (cfg_we && !busy_q) begin
         tab_in_q[cfg_layer]    <= cfg_total_in;
         tab_out_q[cfg_layer]   <= cfg_total_out;
         tab_iaddr_q[cfg_layer] <= cfg_input_addr;
         tab_oaddr_q[cfg_layer] <= cfg_output_addr;
      end
   end

   // State, layer counters and registered outputs.
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state_q     <= S_IDLE;
         launch_q    <= 1'b0;
         count_q     <= ZERO_CNT;
         cur_layer_q <= ZERO_LYR;
         req_q       <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         tin_q       <= {LWIDTH{1'b0}};
         tout_q      <= {LWIDTH{1'b0}};
         iaddr_q     <= {IMGSIZE{1'b0}};
         oaddr_q     <= {IMGSIZE{1'b0}};
      end else begin
         state_q     <= state_d;
         launch_q    <= launch_d;
         count_q     <= count_d;
         cur_layer_q <= cur_layer_d;
         req_q       <= req_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         tin_q       <= tin_d;
         tout_q      <= tout_d;
         iaddr_q     <= iaddr_d;
         oaddr_q     <= oaddr_d;
      end
   end

   // Next-state logic, including the layer counter advance.
   always_comb begin
      state_d     = state_q;
      launch_d    = 1'b0;
      count_d     = count_q;
      cur_layer_d = cur_layer_q;
      case (state_q)
         S_IDLE: begin
            if (launch_q) begin
               if (count_q != ZERO_CNT) begin
                  state_d = S_FETCH;
               end else begin
                  state_d = S_FIN;
               end
            end else if (start) begin
               launch_d    = 1'b1;
               cur_layer_d = ZERO_LYR;
               if (num_layer > MAX_CNT) begin
                  count_d = MAX_CNT;
               end else begin
                  count_d = num_layer;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            // Empty entries advance immediately without a req.
            if (entry_empty_s) begin
               if (last_layer_s) begin
                  state_d = S_FIN;
               end else begin
                  cur_layer_d = cur_layer_q + ONE_LYR;
                  state_d     = S_FETCH;
               end
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (ack) begin
               if (last_layer_s) begin
                  state_d = S_FIN;
               end else begin
                  cur_layer_d = cur_layer_q + ONE_LYR;
                  state_d     = S_FETCH;
               end
            end else begin
               state_d = S_WAIT;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output logic: pulses and busy follow the state being entered so they
   // line up with it; the descriptor is captured while in FETCH and held.
   always_comb begin
      req_d   = (state_d == S_ISSUE);
      done_d  = (state_d == S_FIN);
      busy_d  = launch_d || (state_d == S_FETCH) ||
                (state_d == S_ISSUE) || (state_d == S_WAIT);
      tin_d   = tin_q;
      tout_d  = tout_q;
      iaddr_d = iaddr_q;
      oaddr_d = oaddr_q;
      if (state_q == S_FETCH) begin
         tin_d   = tab_in_q[cur_layer_q];
         tout_d  = tab_out_q[cur_layer_q];
         iaddr_d = tab_iaddr_q[cur_layer_q];
         oaddr_d = tab_oaddr_q[cur_layer_q];
      end else begin
         tin_d   = tin_q;
      end
   end

   assign req         = req_q;
   assign done        = done_q;
   assign busy        = busy_q;
   assign cur_layer   = cur_layer_q;
   assign total_in    = tin_q;
   assign total_out   = tout_q;
   assign input_addr  = iaddr_q;
   assign output_addr = oaddr_q;

endmodule

// File: doc/gobou_layer_seq.md
Name: gobou_layer_seq

Overview:
- Layer scheduler in front of the gobou fully-connected engine.
- Holds a small descriptor table, one entry per layer: total_in, total_out, input_addr, output_addr.
- On start, runs the layers back-to-back. For each layer it presents the descriptor, pulses req, and waits for gobou ack.
- Lets the host launch a whole multi-layer MLP with one start instead of per-layer handshakes.

Parameters:
- LWIDTH, 10, width of the total_in/total_out unit counts (matches gobou).
- IMGSIZE, 12, image-memory address width (matches gobou).
- MAXLAYER, 8, number of descriptor table entries.
- LAYERLOG, 3, log2(MAXLAYER).

Ports:
- clk  in  1  system clock.
- xrst  in  1  asynchronous active-low reset.
- cfg_we  in  1  write descriptor cfg_layer this cycle.
- cfg_layer  in  LAYERLOG  descriptor index.
- cfg_total_in  in  LWIDTH  input count for that layer.
- cfg_total_out  in  LWIDTH  output count for that layer.
- cfg_input_addr  in  IMGSIZE  input base address.
- cfg_output_addr  in  IMGSIZE  output base address.
- num_layer  in  LAYERLOG+1  layers to run; sampled at start.
- start  in  1  single-cycle launch request.
- ack  in  1  gobou layer-complete pulse.
- req  out  1  single-cycle launch pulse to gobou.
- total_in  out  LWIDTH  to gobou.
- total_out  out  LWIDTH  to gobou.
- input_addr  out  IMGSIZE  to gobou.
- output_addr  out  IMGSIZE  to gobou.
- cur_layer  out  LAYERLOG  index of the active layer.
- busy  out  1  sequence in progress.
- done  out  1  single-cycle completion pulse.

Behaviour:
- Reset (xrst=0, async):
  - State IDLE.
  - req, busy, done = 0.
  - cur_layer, total_in, total_out, input_addr, output_addr = 0.
  - Layer-count register = 0.
  - Descriptor table contents are undefined after reset; the host must rewrite them.
- Reset mid-sequence aborts immediately. No done pulse; any later ack is ignored.
- Table writes:
  - Synchronous, accepted only when busy=0. cfg_we while busy=1 is dropped and the table is unchanged.
  - A write to an index in a cycle where start is also seen takes effect before that layer is fetched (write-then-read ordering).
- States:
  - IDLE, FETCH, ISSUE, WAIT, FIN.
- IDLE:
  - start=1 latches min(num_layer, MAXLAYER) into the layer-count register and clears cur_layer.
  - Then go to FETCH if the count is nonzero, else FIN.
  - busy=1 from the cycle after start.
- FETCH:
  - Registers table[cur_layer] onto the total_*/\*_addr outputs.
  - If the entry has total_in==0 or total_out==0, the layer is skipped with no req. Go to the advance step (below).
  - Otherwise go to ISSUE.
- ISSUE:
  - req=1 for exactly one cycle; descriptor outputs are stable.
  - Go to WAIT.
  - Latency from start to the first req is 3 cycles (start at T0, req at T3).
- WAIT:
  - Descriptor outputs stay held until ack.
  - On ack=1, advance: if cur_layer == count-1 go to FIN, else increment cur_layer and go to FETCH.
  - Inter-layer gap is ack at T, next req at T+2.
- FIN:
  - done=1 for one cycle, busy=0 the next cycle, return to IDLE.
  - Descriptor outputs keep the last values.
- Ignored inputs:
  - ack outside WAIT (including in the ISSUE cycle) is ignored.
  - start while busy is ignored.
- Counter wrap: cur_layer never exceeds count-1, so there is no wrap for num_layer ≤ MAXLAYER.
- Clamping: num_layer > MAXLAYER (e.g. 9..15) runs exactly MAXLAYER layers.
- Address chaining: no automatic ping-pong. Addresses come verbatim from the table.

Test Plan:
- Three-layer run:
  - Setup: load L0 (in=784, out=100, ia=0, oa=1000), L1 (100, 10, 1000, 1200), L2 (10, 2, 1200, 1300); num_layer=3; start.
  - Expect: 3 req pulses with the matching descriptor values; ack returned 20 cycles after each req.
  - Expect: next req 2 cycles after each ack; done exactly 1 cycle after the final ack, 1 cycle wide; busy low the following cycle.
- Zero layers: num_layer=0, start -> no req; done at T2; busy high only at T1.
- Skip entry: 3 layers with L1.total_out=0 -> only 2 req pulses (L0, L2); cur_layer passes through 1 with no req; done after L2 ack.
- Protocol abuse:
  - ack asserted in the ISSUE cycle and during IDLE -> no state advance.
  - start and cfg_we pulsed during WAIT -> ignored; table readback via a later run is unchanged.
- Clamp: num_layer=12 with all 8 entries valid -> exactly 8 req pulses, cur_layer 0..7, then done.
- Reset mid-run:
  - xrst low during WAIT of L1 -> all outputs 0 asynchronously.
  - A later ack produces no req/done.
  - After table reload, a new start runs normally.
